chip8_video_scan: RTL and testbench

Display scanout stage sitting directly downstream of the CPU's VRAM write port. Generates 640x480@60 VGA timing, reads the 128x64 2-bit VRAM through its read port, scales each VRAM pixel to a 4x4 block centred on screen, maps pixel codes to 12-bit RGB, and emits a per-frame pulse the CPU uses as its 60 Hz timer tick.

---
 rtl/chip8_video_scan_if.sv | 48 ++++
 rtl/chip8_video_scan.sv | 162 ++++++++++++++++
 tb/tb_chip8_video_scan.sv | 206 ++++++++++++++++++++
 3 files changed

// File: rtl/chip8_video_scan_if.sv
// ---------------------------------------------------------------------------
// chip8_video_scan_if
// Bundles the VRAM read port and the VGA output pins of the CHIP-8 scanout
// stage.
//   scan_hpos   [6:0]  VRAM read column (scanout -> VRAM)
//   scan_vpos   [5:0]  VRAM read row    (scanout -> VRAM)
//   scan_pixel  [1:0]  VRAM read data   (VRAM -> scanout)
//   vga_hsync          horizontal sync, active low
//   vga_vsync          vertical sync, active low
//   vga_r/g/b   [3:0]  colour
//   frame_start        one-clk pulse at each frame wrap (CPU 60 Hz tick)
// master: the scanout block. slave: VRAM / display / CPU side.
// ---------------------------------------------------------------------------
interface chip8_video_scan_if;
    logic [6:0] scan_hpos;
    logic [5:0] scan_vpos;
    logic [1:0] scan_pixel;
    logic       vga_hsync;
    logic       vga_vsync;
    logic [3:0] vga_r;
    logic [3:0] vga_g;
    logic [3:0] vga_b;
    logic       frame_start;

    modport master (
        output scan_hpos,
        output scan_vpos,
        input  scan_pixel,
        output vga_hsync,
        output vga_vsync,
        output vga_r,
        output vga_g,
        output vga_b,
        output frame_start
    );

    modport slave (
        input  scan_hpos,
        input  scan_vpos,
        output scan_pixel,
        input  vga_hsync,
        input  vga_vsync,
        input  vga_r,
        input  vga_g,
        input  vga_b,
        input  frame_start
    );
endinterface

// File: rtl/chip8_video_scan.sv
// ---------------------------------------------------------------------------
// chip8_video_scan
// VGA scanout for the CHIP-8 128x64 2-bit VRAM. Generates line/frame timing,
// addresses VRAM for a centred window with each VRAM pixel replicated
// (1<<SCALE_LOG2) times in both directions, maps pixel codes to 12-bit RGB
// and pulses frame_start once per frame.
// Ports:
//   clk       system clock
//   reset_n   asynchronous active-low reset
//   pix_ce    pixel clock enable; every register advances only when high
//   vif       master side of chip8_video_scan_if (VRAM read port + VGA pins)
// Colour and sync for counter position N appear two pix_ce cycles after the
// counters show N.
// ---------------------------------------------------------------------------
module chip8_video_scan #(
    parameter int H_ACTIVE   = 640,
    parameter int H_FP       = 16,
    parameter int H_SYNC     = 96,
    parameter int H_BP       = 48,
    parameter int V_ACTIVE   = 480,
    parameter int V_FP       = 10,
    parameter int V_SYNC     = 2,
    parameter int V_BP       = 33,
    parameter int SCALE_LOG2 = 2,
    parameter int X_OFFSET   = 64,
    parameter int Y_OFFSET   = 112
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic               pix_ce,
    chip8_video_scan_if.master vif
);
    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

    localparam logic [9:0] H_LAST   = 10'(H_TOTAL - 1);
    localparam logic [9:0] V_LAST   = 10'(V_TOTAL - 1);
    localparam logic [9:0] H_ACT    = 10'(H_ACTIVE);
    localparam logic [9:0] V_ACT    = 10'(V_ACTIVE);
    localparam logic [9:0] HS_BEGIN = 10'(H_ACTIVE + H_FP);
    localparam logic [9:0] HS_END   = 10'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [9:0] VS_BEGIN = 10'(V_ACTIVE + V_FP);
    localparam logic [9:0] VS_END   = 10'(V_ACTIVE + V_FP + V_SYNC);
    localparam logic [9:0] WIN_X0   = 10'(X_OFFSET);
    localparam logic [9:0] WIN_X1   = 10'(X_OFFSET + (128 << SCALE_LOG2));
    localparam logic [9:0] WIN_Y0   = 10'(Y_OFFSET);
    localparam logic [9:0] WIN_Y1   = 10'(Y_OFFSET + (64 << SCALE_LOG2));

    // Blanking wins over everything, then the border outside the picture.
    function automatic logic [11:0] pixel_colour(input logic       active,
                                                 input logic       window,
                                                 input logic [1:0] code);
        logic [11:0] rgb;
        if (!active) begin
            rgb = 12'h000;
        end else if (!window) begin
            rgb = 12'h222;
        end else begin
            case (code)
                2'b00:   rgb = 12'h000;
                2'b01:   rgb = 12'hFFF;
                2'b10:   rgb = 12'h0F0;
                default: rgb = 12'hF00;
            endcase
        end
        return rgb;
    endfunction

    logic [9:0]  h_cnt_q, h_cnt_d;
    logic [9:0]  v_cnt_q, v_cnt_d;
    logic        active_p0, window_p0, hsync_p0, vsync_p0, last_p0;
    logic [9:0]  h_rel_p0, v_rel_p0;
    logic        active_p1_q, active_p1_d;
    logic        window_p1_q, window_p1_d;
    logic        hsync_p1_q, hsync_p1_d;
    logic        vsync_p1_q, vsync_p1_d;
    logic [1:0]  pixel_p1_q, pixel_p1_d;
    logic [11:0] rgb_p2_q, rgb_p2_d;
    logic        hsync_p2_q, hsync_p2_d;
    logic        vsync_p2_q, vsync_p2_d;

    // ---- stage 0: counters and combinational VRAM address ----
    assign active_p0 = (h_cnt_q < H_ACT) && (v_cnt_q < V_ACT);
    assign window_p0 = (h_cnt_q >= WIN_X0) && (h_cnt_q < WIN_X1) &&
                       (v_cnt_q >= WIN_Y0) && (v_cnt_q < WIN_Y1);
    assign hsync_p0  = !((h_cnt_q >= HS_BEGIN) && (h_cnt_q < HS_END));
    assign vsync_p0  = !((v_cnt_q >= VS_BEGIN) && (v_cnt_q < VS_END));
    assign last_p0   = (h_cnt_q == H_LAST) && (v_cnt_q == V_LAST);
    assign h_rel_p0  = h_cnt_q - WIN_X0;
    assign v_rel_p0  = v_cnt_q - WIN_Y0;

    // The address only moves on pix_ce, so it stays stable until the next
    // enabled edge samples scan_pixel, whatever the pix_ce duty cycle.
    assign vif.scan_hpos   = window_p0 ? 7'(h_rel_p0 >> SCALE_LOG2) : 7'd0;
    assign vif.scan_vpos   = window_p0 ? 6'(v_rel_p0 >> SCALE_LOG2) : 6'd0;
    // Fires in the cycle whose enabled edge wraps (last,last) -> (0,0); the
    // reset-released (0,0) is never reached by a wrap, so it gets no pulse.
    assign vif.frame_start = pix_ce & last_p0;

    always_comb begin
        h_cnt_d     = h_cnt_q;
        v_cnt_d     = v_cnt_q;
        active_p1_d = active_p1_q;
        window_p1_d = window_p1_q;
        hsync_p1_d  = hsync_p1_q;
        vsync_p1_d  = vsync_p1_q;
        pixel_p1_d  = pixel_p1_q;
        rgb_p2_d    = rgb_p2_q;
        hsync_p2_d  = hsync_p2_q;
        vsync_p2_d  = vsync_p2_q;
        if (pix_ce) begin
            if (h_cnt_q == H_LAST) begin
                h_cnt_d = 10'd0;
                v_cnt_d = (v_cnt_q == V_LAST) ? 10'd0 : v_cnt_q + 10'd1;
            end else begin
                h_cnt_d = h_cnt_q + 10'd1;
            end
            // ---- stage 1: decoded position plus the VRAM data it addressed ----
            active_p1_d = active_p0;
            window_p1_d = window_p0;
            hsync_p1_d  = hsync_p0;
            vsync_p1_d  = vsync_p0;
            pixel_p1_d  = vif.scan_pixel;
            // ---- stage 2: palette and sync pins, aligned ----
            rgb_p2_d    = pixel_colour(active_p1_q, window_p1_q, pixel_p1_q);
            hsync_p2_d  = hsync_p1_q;
            vsync_p2_d  = vsync_p1_q;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            h_cnt_q     <= 10'd0;
            v_cnt_q     <= 10'd0;
            active_p1_q <= 1'b0;
            window_p1_q <= 1'b0;
            hsync_p1_q  <= 1'b1;
            vsync_p1_q  <= 1'b1;
            pixel_p1_q  <= 2'b00;
            rgb_p2_q    <= 12'h000;
            hsync_p2_q  <= 1'b1;
            vsync_p2_q  <= 1'b1;
        end else begin
            h_cnt_q     <= h_cnt_d;
            v_cnt_q     <= v_cnt_d;
            active_p1_q <= active_p1_d;
            window_p1_q <= window_p1_d;
            hsync_p1_q  <= hsync_p1_d;
            vsync_p1_q  <= vsync_p1_d;
            pixel_p1_q  <= pixel_p1_d;
            rgb_p2_q    <= rgb_p2_d;
            hsync_p2_q  <= hsync_p2_d;
            vsync_p2_q  <= vsync_p2_d;
        end
    end

    assign vif.vga_hsync = hsync_p2_q;
    assign vif.vga_vsync = vsync_p2_q;
    assign vif.vga_r     = rgb_p2_q[11:8];
    assign vif.vga_g     = rgb_p2_q[7:4];
    assign vif.vga_b     = rgb_p2_q[3:0];
endmodule

// File: tb/tb_chip8_video_scan.sv
// ---------------------------------------------------------------------------
// tb_chip8_video_scan
// Bench for chip8_video_scan with a reduced raster (272x134 total, 2x scale)
// so whole frames fit in a short run. The reference works from a plain count
// of enabled clock edges since reset: position = count mod line/frame size,
// outputs follow the position two enabled edges earlier.
// ---------------------------------------------------------------------------
module tb_chip8_video_scan;
    localparam int HA  = 264;
    localparam int HFP = 2;
    localparam int HSW = 4;
    localparam int HBP = 2;
    localparam int VA  = 130;
    localparam int VFP = 1;
    localparam int VSW = 2;
    localparam int VBP = 1;
    localparam int SL  = 1;
    localparam int XO  = 4;
    localparam int YO  = 1;
    localparam int SC  = 1 << SL;
    localparam int HT  = HA + HFP + HSW + HBP;   // 272
    localparam int VT  = VA + VFP + VSW + VBP;   // 134
    localparam int FT  = HT * VT;                // 36448
    localparam int TARGET = FT + 40 * HT + 150;  // (h=150, v=40) of frame 2

    localparam logic [11:0] PAL [4] = '{12'h000, 12'hFFF, 12'h0F0, 12'hF00};

    logic clk;
    logic reset_n;
    logic pix_ce;
    logic [1:0] vram [0:63][0:127];

    chip8_video_scan_if vif();

    chip8_video_scan #(
        .H_ACTIVE(HA), .H_FP(HFP), .H_SYNC(HSW), .H_BP(HBP),
        .V_ACTIVE(VA), .V_FP(VFP), .V_SYNC(VSW), .V_BP(VBP),
        .SCALE_LOG2(SL), .X_OFFSET(XO), .Y_OFFSET(YO)
    ) dut (
        .clk(clk),
        .reset_n(reset_n),
        .pix_ce(pix_ce),
        .vif(vif)
    );

    assign vif.scan_pixel = vram[vif.scan_vpos][vif.scan_hpos];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference position: enabled edges since the last reset.
    int c = 0;
    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) c <= 0;
        else if (pix_ce) c <= c + 1;
    end

    int  checks   = 0;
    int  failures = 0;
    int  phase    = 0;
    bit  done     = 1'b0;
    bit  timeout  = 1'b0;

    int first_hs_a = -1, hs_line0_low = 0, vs_low = 0, fs_cnt = 0, fs_c = -1;
    int adr_a = -1, adr_b = -1, rgb_border = -1;
    int first_hs_c = -1, rgb_278 = -1, rgb_280 = -1, rgb_551 = -1, rgb_822 = -1;

    function automatic bit in_window(input int h, input int v);
        return (h >= XO) && (h < XO + 128 * SC) && (v >= YO) && (v < YO + 64 * SC);
    endfunction

    function automatic logic [13:0] video_at(input int n);
        int h, v;
        logic hs, vs;
        logic [11:0] rgb;
        h  = n % HT;
        v  = (n / HT) % VT;
        hs = !((h >= HA + HFP) && (h < HA + HFP + HSW));
        vs = !((v >= VA + VFP) && (v < VA + VFP + VSW));
        if (h >= HA || v >= VA)  rgb = 12'h000;
        else if (in_window(h, v)) rgb = PAL[vram[(v - YO) / SC][(h - XO) / SC]];
        else                      rgb = 12'h222;
        return {hs, vs, rgb};
    endfunction

    function automatic logic [12:0] addr_at(input int n);
        int h, v;
        h = n % HT;
        v = (n / HT) % VT;
        if (!in_window(h, v)) return 13'd0;
        return {6'((v - YO) / SC), 7'((h - XO) / SC)};
    endfunction

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s t=%0t c=%0d got=%h expected=%h", name, $time, c, got, exp);
        end
    endtask

    task automatic compare_cycle();
        logic [13:0] got_vid, exp_vid;
        logic [12:0] got_adr;
        logic        exp_fs;
        got_vid = {vif.vga_hsync, vif.vga_vsync, vif.vga_r, vif.vga_g, vif.vga_b};
        got_adr = {vif.scan_vpos, vif.scan_hpos};
        exp_vid = (c < 2) ? {2'b11, 12'h000} : video_at(c - 2);
        exp_fs  = reset_n && pix_ce && ((c % FT) == FT - 1);
        check("video", 32'(got_vid), 32'(exp_vid));
        check("address", 32'(got_adr), 32'(addr_at(c)));
        check("frame_start", 32'(vif.frame_start), 32'(exp_fs));
        if (phase == 1) begin
            if (!vif.vga_hsync && first_hs_a < 0) first_hs_a = c;
            if (!vif.vga_hsync && c < HT + 2) hs_line0_low++;
            if (!vif.vga_vsync) vs_low++;
            if (vif.frame_start) begin fs_cnt++; fs_c = c; end
            if (c == 128 * HT + 259) adr_a = int'(got_adr);
            if (c == 128 * HT + 260) adr_b = int'(got_adr);
            if (c == 128 * HT + 262) rgb_border = int'(got_vid[11:0]);
        end
        if (phase == 3) begin
            if (!vif.vga_hsync && first_hs_c < 0) first_hs_c = c;
            if (c == 278) rgb_278 = int'(got_vid[11:0]);
            if (c == 280) rgb_280 = int'(got_vid[11:0]);
            if (c == 551) rgb_551 = int'(got_vid[11:0]);
            if (c == 822) rgb_822 = int'(got_vid[11:0]);
        end
    endtask

    task automatic final_checks();
        check("hsync_first_fall", 32'(first_hs_a), 32'(268));
        check("hsync_width_line0", 32'(hs_line0_low), 32'(4));
        check("vsync_width", 32'(vs_low), 32'(544));
        check("frame_start_count", 32'(fs_cnt), 32'(1));
        check("frame_start_pos", 32'(fs_c), 32'(36447));
        check("addr_last_col_row", 32'(adr_a), 32'({6'd63, 7'd127}));
        check("addr_past_window", 32'(adr_b), 32'(0));
        check("border_colour", 32'(rgb_border), 32'(12'h222));
        check("hsync_after_reset", 32'(first_hs_c), 32'(268));
        check("pix00_first", 32'(rgb_278), 32'(12'hFFF));
        check("pix01_black", 32'(rgb_280), 32'(12'h000));
        check("pix00_row2", 32'(rgb_551), 32'(12'hFFF));
        check("pix10_black", 32'(rgb_822), 32'(12'h000));
        check("reach_target", 32'(timeout), 32'(0));
    endtask

    // Compare process: every clock (away from the active edge) and right
    // after any asynchronous reset assertion.
    always begin
        @(negedge clk or negedge reset_n);
        #1;
        compare_cycle();
        if (done) begin
            final_checks();
            $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
            $finish;
        end
    end

    initial begin
        int guard;
        pix_ce  = 1'b0;
        reset_n = 1'b0;
        for (int v = 0; v < 64; v++)
            for (int h = 0; h < 128; h++)
                vram[v][h] = 2'($urandom_range(3, 0));
        repeat (5) @(posedge clk);
        #1;
        phase   = 1;
        reset_n = 1'b1;
        pix_ce  = 1'b1;
        // Full-rate run over one whole frame and into the next.
        repeat (FT + 300) @(posedge clk);
        #1;
        phase = 2;
        // Half-rate run up to a point in the middle of the picture.
        guard = 0;
        while (c != TARGET && guard < 40000) begin
            pix_ce = ~pix_ce;
            @(posedge clk);
            #1;
            guard++;
        end
        if (c != TARGET) timeout = 1'b1;
        #2;
        reset_n = 1'b0;
        pix_ce  = 1'b0;
        for (int v = 0; v < 64; v++)
            for (int h = 0; h < 128; h++)
                vram[v][h] = 2'b00;
        vram[0][0] = 2'b01;
        repeat (3) @(posedge clk);
        #1;
        phase   = 3;
        reset_n = 1'b1;
        // Random pix_ce duty after the mid-frame reset.
        repeat (6000) begin
            pix_ce = 1'($urandom_range(1, 0));
            @(posedge clk);
            #1;
        end
        pix_ce = 1'b0;
        done   = 1'b1;
    end
endmodule
